// File: rtl/tap_collector_pkg.sv
// Shared constants and types for the tap collector: sample width default,
// group size and the lane-index width used by the collect stage.
package tap_collector_pkg;

  localparam int unsigned DATA_W_DEF = 13;
  localparam int unsigned LANES_C    = 4;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [1:0] {
    OUT_EMPTY     = 2'd0,
    OUT_FULL      = 2'd1,
    OUT_FULL_PEND = 2'd2
  } out_state_e;

endpackage

// File: rtl/tap_out_reg.sv
// Output register plus one-deep pending slot for completed groups; presents
// groups with valid/ready and back-pressures the collector while full.
module tap_out_reg
  import tap_collector_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANES_C*DATA_W-1:0]   grp_data,
  input  logic [2:0]                  grp_count,
  input  logic                        grp_valid,
  output logic [LANES_C*DATA_W-1:0]   out_data,
  output logic [2:0]                  out_count,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        pending
);

  out_state_e state, state_n;
  logic       load_new;
  logic       load_pend;
  logic       drain;

  logic [LANES_C*DATA_W-1:0] pend_data;
  logic [2:0]                pend_count;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= OUT_EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load_new  = 1'b0;
    load_pend = 1'b0;
    drain     = 1'b0;
    case (state)
      OUT_EMPTY: begin
        if (grp_valid) begin
          load_new = 1'b1;
          state_n  = OUT_FULL;
        end
      end
      OUT_FULL: begin
        // A new group and a consumed one on the same edge swap with no bubble.
        if (grp_valid) begin
          if (out_ready) begin
            load_new = 1'b1;
          end else begin
            load_pend = 1'b1;
            state_n   = OUT_FULL_PEND;
          end
        end else if (out_ready) begin
          state_n = OUT_EMPTY;
        end
      end
      OUT_FULL_PEND: begin
        if (out_ready) begin
          drain   = 1'b1;
          state_n = OUT_FULL;
        end
      end
      default: state_n = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_count  <= '0;
      pend_data  <= '0;
      pend_count <= '0;
    end else begin
      if (load_new) begin
        out_data  <= grp_data;
        out_count <= grp_count;
      end else if (drain) begin
        out_data  <= pend_data;
        out_count <= pend_count;
      end
      if (load_pend) begin
        pend_data  <= grp_data;
        pend_count <= grp_count;
      end
    end
  end

  assign out_valid = (state != OUT_EMPTY);
  assign pending   = (state == OUT_FULL_PEND);

endmodule

// File: rtl/tap_collector.sv
// Gathers serial samples into groups of four (or fewer on in_last), zero-pads
// unfilled lanes and hands each group to the output register.
module tap_collector
  import tap_collector_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LANES  = LANES_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_d,
  output logic [2:0]        out_count,
  output logic              out_valid,
  input  logic              out_ready
);

  if (LANES != LANES_C) begin : g_lanes_check
    $error("tap_collector: LANES must be 4");
  end

  logic [IDX_W-1:0]          idx;
  logic [DATA_W-1:0]         lane_q [LANES_C];
  logic                      accept;
  logic                      complete;
  logic                      pending;
  logic [LANES_C*DATA_W-1:0] grp_data;
  logic [2:0]                grp_count;
  logic [LANES_C*DATA_W-1:0] out_data;

  assign in_ready = rst_n & ~pending;
  assign accept   = in_valid & in_ready;
  assign complete = accept & (in_last | (idx == IDX_W'(LANES_C - 1)));

  // The completing sample is merged in directly; lanes above it read zero,
  // so stale collect registers from an earlier group never leak out.
  always_comb begin
    grp_data = '0;
    for (int unsigned i = 0; i < LANES_C; i++) begin
      if (IDX_W'(i) < idx)       grp_data[i*DATA_W +: DATA_W] = lane_q[i];
      else if (IDX_W'(i) == idx) grp_data[i*DATA_W +: DATA_W] = in_data;
    end
  end

  assign grp_count = {1'b0, idx} + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      lane_q <= '{default: '0};
    end else if (accept) begin
      lane_q[idx] <= in_data;
      idx         <= complete ? '0 : idx + 1'b1;
    end
  end

  tap_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .grp_data  (grp_data),
    .grp_count (grp_count),
    .grp_valid (complete),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending)
  );

  assign out_a = out_data[0*DATA_W +: DATA_W];
  assign out_b = out_data[1*DATA_W +: DATA_W];
  assign out_c = out_data[2*DATA_W +: DATA_W];
  assign out_d = out_data[3*DATA_W +: DATA_W];

endmodule

// File: tb/tb_tap_collector.sv
// Directed bench for tap_collector: queue-based group model checked every
// cycle, plus literal expectations on the sequence of emitted groups.
module tb_tap_collector;

  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_a, out_b, out_c, out_d;
  logic [2:0]    out_count;
  logic          out_valid;
  logic          out_ready = 1'b0;

  tap_collector #(
    .DATA_W (DW),
    .LANES  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane [4];
    int cnt;
  } grp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cycles = 0;
  bit   live = 1'b0;
  grp_t q [$];
  int   cur [$];
  grp_t mlog [$];
  grp_t dlog [$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: completed-but-unconsumed groups in a queue; at most two may be held.
  bit   m_acc, m_xfer;
  grp_t m_g;
  always @(posedge clk) begin
    cycles++;
    if (!rst_n) begin
      q.delete();
      cur.delete();
      live = 1'b1;
    end else if (live) begin
      m_acc  = in_valid && (q.size() < 2);
      m_xfer = out_ready && (q.size() > 0);
      if (m_xfer) begin
        mlog.push_back(q[0]);
        void'(q.pop_front());
      end
      if (m_acc) begin
        cur.push_back(int'(in_data));
        if (in_last || cur.size() == 4) begin
          m_g.cnt = cur.size();
          for (int i = 0; i < 4; i++) m_g.lane[i] = (i < cur.size()) ? cur[i] : 0;
          q.push_back(m_g);
          cur.delete();
        end
      end
    end
  end

  grp_t d_g;
  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      chk("in_ready", int'(in_ready), (rst_n && q.size() < 2) ? 1 : 0);
      if (q.size() > 0) begin
        chk("out_a", int'(out_a), q[0].lane[0]);
        chk("out_b", int'(out_b), q[0].lane[1]);
        chk("out_c", int'(out_c), q[0].lane[2]);
        chk("out_d", int'(out_d), q[0].lane[3]);
        chk("out_count", int'(out_count), q[0].cnt);
      end
      if (out_valid && out_ready) begin
        d_g.lane[0] = int'(out_a);
        d_g.lane[1] = int'(out_b);
        d_g.lane[2] = int'(out_c);
        d_g.lane[3] = int'(out_d);
        d_g.cnt     = int'(out_count);
        dlog.push_back(d_g);
      end
    end
  end

  task automatic send(input int d, input bit l);
    logic ok;
    in_data  = DW'(d);
    in_last  = l;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_tbl [10][5] = '{
    '{1, 2, 3, 4, 4},
    '{5, 6, 0, 0, 2},
    '{10, 11, 12, 13, 4},
    '{14, 15, 16, 17, 4},
    '{20, 21, 22, 23, 4},
    '{24, 25, 26, 27, 4},
    '{28, 29, 30, 31, 4},
    '{32, 33, 34, 35, 4},
    '{7, 8, 9, 10, 4},
    '{8191, 0, 0, 0, 1}
  };

  int c0;

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Full group, presented for exactly one cycle.
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    chk("g1_valid", int'(out_valid), 1);
    chk("g1_a", int'(out_a), 1);
    chk("g1_d", int'(out_d), 4);
    chk("g1_count", int'(out_count), 4);
    idle(1);
    chk("g1_one_cycle", int'(out_valid), 0);

    // Early close with zero padding.
    send(5, 1'b0);
    send(6, 1'b1);
    chk("g2_b", int'(out_b), 6);
    chk("g2_c", int'(out_c), 0);
    chk("g2_count", int'(out_count), 2);
    idle(2);

    // Back-pressure: one presented, one pending, input stalled.
    out_ready = 1'b0;
    for (int i = 10; i <= 17; i++) send(i, 1'b0);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_a", int'(out_a), 10);
    idle(3);
    chk("stall_hold_a", int'(out_a), 10);
    chk("stall_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    idle(3);
    chk("drain_in_ready", int'(in_ready), 1);

    // Continuous stream: one sample per cycle, no stalls.
    c0 = cycles;
    for (int i = 20; i <= 35; i++) send(i, 1'b0);
    chk("stream_cycles", cycles - c0, 16);
    idle(3);

    // Reset mid-group discards the partial group.
    send(40, 1'b0);
    send(41, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 7; i <= 10; i++) send(i, 1'b0);
    idle(3);

    // Single max-value sample closed by in_last.
    send(13'h1FFF, 1'b1);
    chk("max_a", int'(out_a), 8191);
    chk("max_b", int'(out_b), 0);
    chk("max_count", int'(out_count), 1);
    idle(5);

    chk("dut_groups", dlog.size(), 10);
    chk("model_groups", mlog.size(), 10);
    for (int g = 0; g < 10; g++) begin
      for (int k = 0; k < 5; k++) begin
        if (g < mlog.size())
          chk($sformatf("model_g%0d_f%0d", g, k), (k < 4) ? mlog[g].lane[k] : mlog[g].cnt, exp_tbl[g][k]);
        if (g < dlog.size())
          chk($sformatf("dut_g%0d_f%0d", g, k), (k < 4) ? dlog[g].lane[k] : dlog[g].cnt, exp_tbl[g][k]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
